flog2_frac_iter: RTL
====================

Name: flog2_frac_iter

Overview:
- Parametrised iterative fractional-log2 unit for the FLOG datapath.
- Takes a normalised mantissa 1.M in [1,2) and produces the fractional bits of log2(1.M), one bit per cycle, by repeated squaring.
- Adds over the previous generation: width/precision parameters, ready/valid handshake on both sides with output back-pressure, early termination on exact 1.0, and an invalid-input flag.
- Sits between mantissa extraction and the exponent/fraction recombination stage.

Parameters:
- MAN_W, 16, mantissa width, Q1.(MAN_W-1) fixed point; MSB is the integer 1.
- FRAC_W, 16, number of fractional result bits produced; 1 ≤ FRAC_W ≤ 32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input mantissa valid.
- in_ready  out  1  block can accept a mantissa.
- in_man  in  MAN_W  mantissa, Q1.(MAN_W-1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_frac  out  FRAC_W  log2 fraction, 0.b(FRAC_W-1)..b0.
- out_err  out  1  input had MSB=0 (not normalised).

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_frac=0, out_err=0, internal man/square/count cleared.
- States:
  - IDLE: in_ready=1. On in_valid: load man=in_man and sq=in_man*in_man (2*MAN_W bits), count=FRAC_W-1 (or FRAC_W with rounding), clear result. Go to EVAL. If in_man[MAN_W-1]=0, set err and go to DONE instead.
  - EVAL: one result bit per cycle, MSB first, at position count.
    - If sq[2*MAN_W-1]=1: bit=1, man=sq[2*MAN_W-1:MAN_W].
    - Else: bit=0, man=sq[2*MAN_W-2:MAN_W-1].
    - sq=man_next*man_next. Truncation only; no rounding between iterations.
    - If count=0, go to DONE; else decrement count.
    - Early termination: if man equals exactly 1.0 (only MSB set) on entry to an EVAL cycle, all remaining bits are 0. Go to DONE that cycle without writing a bit.
  - DONE: out_valid=1; out_frac/out_err stable. On out_ready, go to IDLE. in_ready=0 in DONE, so no accept in the same cycle as output handshake.
- in_ready=(state==IDLE); out_valid=(state==DONE). Both registered-state decodes, no combinational path from in_valid/out_ready.
- Latency: accept at edge T.
  - Normal: out_valid high from cycle T+FRAC_W+1.
  - Early termination at 1.0 input: T+2.
  - Error: T+1.
- Back-pressure: while out_valid=1 and out_ready=0, outputs hold indefinitely and in_ready stays 0.
- in_man is sampled only on the accept cycle; later changes are ignored.
- out_err=1 forces out_frac=0.
- Reset mid-operation: any state returns to IDLE next edge; partial result discarded; no out_valid pulse.

Optional Feature:
- Macro: FLOG_ROUND_EN.
- Defined:
  - Runs one extra EVAL iteration to produce a guard bit; latency +1 cycle.
  - On entry to DONE, out_frac = truncated + guard (round half-up).
  - Carry out of the MSB saturates out_frac to all ones.
  - Early termination gives guard=0.
- Undefined: plain truncation, FRAC_W iterations, no guard logic.

Test Plan (MAN_W=8, FRAC_W=8 unless noted):
- in_man=8'hC0 (1.5), out_ready=1 -> out_frac=8'h95, out_err=0, out_valid at T+9 for exactly one cycle; with FLOG_ROUND_EN -> 8'h96 at T+10.
- in_man=8'h80 (1.0) -> out_frac=8'h00 at T+2 (early termination), out_err=0.
- in_man=8'h40 (MSB 0) -> out_err=1, out_frac=8'h00, out_valid at T+1.
- in_man=8'hC0, out_ready held 0 for 5 cycles after out_valid -> out_frac=8'h95 stable, in_ready=0 throughout; handshake then in_ready=1 next cycle.
- rst pulsed at cycle T+4 of an 8'hC0 computation -> next cycle in_ready=1, out_valid=0, out_frac=0; a following 8'hC0 yields 8'h95 normally.
- Back-to-back inputs with in_valid held high -> second accept occurs the cycle after the first output handshake; both results correct (8'hC0->8'h95, 8'h80->8'h00).

Source files
------------

// File: rtl/flog2_frac_iter.sv
// Iterative fractional log2 of a normalised mantissa 1.M by repeated squaring, one bit per cycle.
// Optional macro FLOG_ROUND_EN: one extra guard iteration and round half-up (saturating) into out_frac.
module flog2_frac_iter #(
    parameter int MAN_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAN_W-1:0]  in_man,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_err
);

`ifdef FLOG_ROUND_EN
    localparam int RES_W = FRAC_W + 1;
`else
    localparam int RES_W = FRAC_W;
`endif
    localparam int CNT_W = $clog2(RES_W + 1);
    localparam int SQ_W  = 2 * MAN_W;
    localparam logic [MAN_W-1:0] MAN_ONE = {1'b1, {(MAN_W-1){1'b0}}};

    // state | meaning
    // IDLE  | waiting for a mantissa, in_ready high
    // EVAL  | producing one result bit per cycle
    // DONE  | result held on out_frac/out_err until out_ready
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t             state_q, state_d;
    logic [MAN_W-1:0]   man_q, man_d;
    logic [SQ_W-1:0]    sq_q, sq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [FRAC_W-1:0]  frac_q, frac_d;
    logic               err_q, err_d;
    logic               eval_bit;
    logic [MAN_W-1:0]   man_eval;

    function automatic logic [SQ_W-1:0] square(input logic [MAN_W-1:0] m);
        return {{MAN_W{1'b0}}, m} * {{MAN_W{1'b0}}, m};
    endfunction

    function automatic logic [FRAC_W-1:0] finalise(input logic [RES_W-1:0] r);
`ifdef FLOG_ROUND_EN
        logic [FRAC_W:0] sum;
        sum = {1'b0, r[RES_W-1:1]} + {{FRAC_W{1'b0}}, r[0]};
        return sum[FRAC_W] ? {FRAC_W{1'b1}} : sum[FRAC_W-1:0];
`else
        return r;
`endif
    endfunction

    // A square >= 2.0 yields a 1 bit and is renormalised by halving.
    assign eval_bit = sq_q[SQ_W-1];
    assign man_eval = eval_bit ? sq_q[SQ_W-1 -: MAN_W] : sq_q[SQ_W-2 -: MAN_W];

    always_comb begin
        state_d = state_q;
        man_d   = man_q;
        sq_d    = sq_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        frac_d  = frac_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    man_d = in_man;
                    sq_d  = square(in_man);
                    cnt_d = CNT_W'(RES_W - 1);
                    res_d = '0;
                    err_d = ~in_man[MAN_W-1];
                    if (in_man[MAN_W-1]) begin
                        state_d = EVAL;
                    end else begin
                        frac_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            EVAL: begin
                if (man_q == MAN_ONE) begin
                    frac_d  = finalise(res_q);
                    state_d = DONE;
                end else begin
                    res_d = res_q | (RES_W'(eval_bit) << cnt_q);
                    man_d = man_eval;
                    sq_d  = square(man_eval);
                    if (cnt_q == '0) begin
                        frac_d  = finalise(res_d);
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            man_q   <= '0;
            sq_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            frac_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            man_q   <= man_d;
            sq_q    <= sq_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            frac_q  <= frac_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_frac  = frac_q;
    assign out_err   = err_q;

endmodule
